// File: rtl/melody_chime_slot.sv
// ---------------------------------------------------------------------------
// melody_chime_slot
//
// One tone-generator slot of the chime. It sits on the receiving end of the
// sequencer's slot write interface. A note-on write latches the half-period
// divider, restarts the square-wave oscillator in its high phase and
// retriggers a decaying envelope. The slot drives a signed amplitude sample
// (+ENV while the phase is high, -ENV while it is low) to the slot mixer.
//
// Ports:
//   CK_i           system clock, all state on its rising edge
//   XAR_i          asynchronous reset, active low (board provides a pull-up)
//   TIMING_1ms_i   1 ms clock-enable pulse, one cycle wide
//   TIMING_TONE_i  100 kHz tone clock-enable pulse, one cycle wide
//   WT_REQ_i       slot write request, one cycle pulse
//   SLOT_divs_i    half-period divider minus 1, valid with WT_REQ_i
//   SLOT_note_i    1 = note-on, 0 = no change, valid with WT_REQ_i
//   WAVE_o         signed sample, C_ENV_W+1 bits, +ENV or -ENV
//   SQR_o          raw oscillator phase
//   ACTIVE_o       1 while the envelope is non-zero
//
// Parameters:
//   C_ENV_W        envelope width, peak level is 2**C_ENV_W-1
//   C_DECAY_TC     number of 1 ms ticks per envelope decay step
//
// Build option:
//   MELODY_CHIME_SLOT_EXP_DECAY_EN  defined   -> exponential decay tail
//                                   undefined -> linear decay, one LSB/step
// ---------------------------------------------------------------------------
module melody_chime_slot #(
    parameter int C_ENV_W    = 8,
    parameter int C_DECAY_TC = 4
) (
    input  logic               CK_i,
    input  logic               XAR_i,
    input  logic               TIMING_1ms_i,
    input  logic               TIMING_TONE_i,
    input  logic               WT_REQ_i,
    input  logic [7:0]         SLOT_divs_i,
    input  logic               SLOT_note_i,
    output logic [C_ENV_W:0]   WAVE_o,
    output logic               SQR_o,
    output logic               ACTIVE_o
);

    // Decay counter only needs to hold C_DECAY_TC-1; keep at least one bit.
    localparam int C_DCW = (C_DECAY_TC > 1) ? $clog2(C_DECAY_TC) : 1;
    localparam logic [C_DCW-1:0]   C_DECAY_LOAD = C_DCW'(C_DECAY_TC - 1);
    localparam logic [C_ENV_W-1:0] C_ENV_PEAK   = {C_ENV_W{1'b1}};

    // Slot state
    logic [7:0]         r_div;
    logic [7:0]         r_tone_ctr;
    logic               r_phase;
    logic [C_ENV_W-1:0] r_env;
    logic [C_DCW-1:0]   r_decay_ctr;

    // Registered outputs
    logic [C_ENV_W:0]   r_wave;
    logic               r_sqr;
    logic               r_active;

    // Combinational helpers
    logic               w_note_on;
    logic               w_env_nz;
    logic [C_ENV_W-1:0] w_env_step;
    logic [C_ENV_W:0]   w_env_pos;
    logic [C_ENV_W:0]   w_wave_next;

    // A write with note=0 is a no-op; only a note-on touches the slot.
    assign w_note_on = WT_REQ_i & SLOT_note_i;
    assign w_env_nz  = (r_env != '0);

    // Next envelope level for one decay step. Only used while ENV != 0, so
    // the subtraction can never wrap below zero.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every
        // path (default first); otherwise synthesis infers a latch.
        w_env_step = r_env;
`ifdef MELODY_CHIME_SLOT_EXP_DECAY_EN
        // Drop by 1/8 of the level; below 8 the shift yields 0, so the
        // extra LSB keeps the tail moving until it reaches 0.
        w_env_step = r_env - (r_env >> 3)
                   - ((32'(r_env) < 32'd8) ? C_ENV_W'(1) : C_ENV_W'(0));
`else
        w_env_step = r_env - C_ENV_W'(1);
`endif
    end

    // Sign the envelope by the oscillator phase. Negation is done one bit
    // wider than ENV so the full peak level has a representable negative.
    assign w_env_pos = {1'b0, r_env};

    always_comb begin
        w_wave_next = w_env_pos;
        if (!r_phase) begin
            w_wave_next = -w_env_pos;
        end
    end

    // Divider, oscillator and envelope. A note-on write has priority over
    // both tick enables in the same cycle; those ticks are simply dropped.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            // NOTE: sequential state uses non-blocking (<=) assignments so
            // every register samples the pre-edge values of the others.
            r_div       <= '0;
            r_tone_ctr  <= '0;
            r_phase     <= 1'b0;
            r_env       <= '0;
            r_decay_ctr <= '0;
        end else if (w_note_on) begin
            r_div       <= SLOT_divs_i;
            r_tone_ctr  <= SLOT_divs_i;
            r_phase     <= 1'b1;
            r_env       <= C_ENV_PEAK;
            r_decay_ctr <= C_DECAY_LOAD;
        end else begin
            // Oscillator free-runs even when silent: half period is DIV+1
            // tone ticks.
            if (TIMING_TONE_i) begin
                if (r_tone_ctr == '0) begin
                    r_tone_ctr <= r_div;
                    r_phase    <= ~r_phase;
                end else begin
                    r_tone_ctr <= r_tone_ctr - 8'd1;
                end
            end

            // Envelope freezes (together with its prescaler) once it is 0.
            if (TIMING_1ms_i && w_env_nz) begin
                if (r_decay_ctr == '0) begin
                    r_decay_ctr <= C_DECAY_LOAD;
                    r_env       <= w_env_step;
                end else begin
                    r_decay_ctr <= r_decay_ctr - C_DCW'(1);
                end
            end
        end
    end

    // Output register: one cycle behind the slot state, so a note-on at
    // edge n shows as +peak after edge n+1.
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            r_wave   <= '0;
            r_sqr    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_wave   <= w_wave_next;
            r_sqr    <= r_phase;
            r_active <= w_env_nz;
        end
    end

    assign WAVE_o   = r_wave;
    assign SQR_o    = r_sqr;
    assign ACTIVE_o = r_active;

endmodule

// File: tb/tb_melody_chime_slot.sv
// ---------------------------------------------------------------------------
// tb_melody_chime_slot
//
// Directed bench for one chime slot with default parameters (8-bit envelope,
// 4 ms per decay step). Every stimulus step drives one clock of inputs and
// then one idle clock, so the registered outputs show the slot state that
// the step produced; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_melody_chime_slot;

    logic       ck;
    logic       xar;
    logic       t_1ms;
    logic       t_tone;
    logic       wt_req;
    logic [7:0] divs;
    logic       note;
    logic [8:0] wave;
    logic       sqr;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;

    melody_chime_slot #(
        .C_ENV_W    (8),
        .C_DECAY_TC (4)
    ) dut (
        .CK_i          (ck),
        .XAR_i         (xar),
        .TIMING_1ms_i  (t_1ms),
        .TIMING_TONE_i (t_tone),
        .WT_REQ_i      (wt_req),
        .SLOT_divs_i   (divs),
        .SLOT_note_i   (note),
        .WAVE_o        (wave),
        .SQR_o         (sqr),
        .ACTIVE_o      (active)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Hard bound on run time in case stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       req;
        logic [7:0] divs;
        logic       note;
        logic       tone;
        logic       ms;
        logic [8:0] exp_wave;
        logic       exp_sqr;
        logic       exp_act;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic req, logic [7:0] d, logic n, logic tn,
                                logic m, logic [8:0] w, logic s, logic a);
        vec_t v;
        v.req = req; v.divs = d; v.note = n; v.tone = tn; v.ms = m;
        v.exp_wave = w; v.exp_sqr = s; v.exp_act = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act_v,
                         input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act_v, exp_v);
        end
    endtask

    task automatic check_out(input string name, input logic [8:0] w,
                             input logic s, input logic a);
        check({name, ".wave"},   32'(wave),   32'(w));
        check({name, ".sqr"},    32'(sqr),    32'(s));
        check({name, ".active"}, 32'(active), 32'(a));
    endtask

    // One active clock with the given inputs, then one idle clock so the
    // output register catches up; returns at the following falling edge.
    task automatic step(input logic req, input logic [7:0] d, input logic n,
                        input logic tn, input logic m);
        wt_req = req; divs = d; note = n; t_tone = tn; t_1ms = m;
        @(posedge ck);
        #1;
        wt_req = 1'b0; divs = 8'h00; note = 1'b0; t_tone = 1'b0; t_1ms = 1'b0;
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic ms_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tone_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Table: divider 1 gives a half period of two tone ticks.
        vecs[0]  = mk(0, 8'd0,  0, 0, 0, 9'h000, 0, 0); // idle after reset
        vecs[1]  = mk(1, 8'd1,  1, 0, 0, 9'h0FF, 1, 1); // note-on -> +255
        vecs[2]  = mk(0, 8'd0,  0, 1, 0, 9'h0FF, 1, 1); // ctr 1->0
        vecs[3]  = mk(0, 8'd0,  0, 1, 0, 9'h101, 0, 1); // toggle -> -255
        vecs[4]  = mk(0, 8'd0,  0, 1, 0, 9'h101, 0, 1);
        vecs[5]  = mk(0, 8'd0,  0, 1, 0, 9'h0FF, 1, 1); // toggle back
        vecs[6]  = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1); // decay ctr 3->2
        vecs[7]  = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1);
        vecs[8]  = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1);
        vecs[9]  = mk(0, 8'd0,  0, 0, 1, 9'h0FE, 1, 1); // 4th ms -> 254
        vecs[10] = mk(1, 8'd20, 0, 0, 0, 9'h0FE, 1, 1); // note=0 ignored
        vecs[11] = mk(0, 8'd0,  0, 1, 0, 9'h0FE, 1, 1);
        vecs[12] = mk(0, 8'd0,  0, 1, 0, 9'h102, 0, 1); // -254, pitch kept
        vecs[13] = mk(0, 8'd0,  0, 1, 0, 9'h102, 0, 1);
        vecs[14] = mk(0, 8'd0,  0, 1, 0, 9'h0FE, 1, 1);
        vecs[15] = mk(1, 8'd0,  1, 1, 1, 9'h0FF, 1, 1); // write vs both ticks
        vecs[16] = mk(0, 8'd0,  0, 1, 0, 9'h101, 0, 1); // DIV=0: every tick
        vecs[17] = mk(0, 8'd0,  0, 1, 0, 9'h0FF, 1, 1);
        vecs[18] = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1); // collision ms dropped
        vecs[19] = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1);
        vecs[20] = mk(0, 8'd0,  0, 0, 1, 9'h0FF, 1, 1);
        vecs[21] = mk(0, 8'd0,  0, 0, 1, 9'h0FE, 1, 1);

        wt_req = 1'b0; divs = 8'h00; note = 1'b0; t_tone = 1'b0; t_1ms = 1'b0;

        // Reset held with the clock running, then released.
        xar = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        check_out("reset_hold", 9'h000, 1'b0, 1'b0);
        xar = 1'b1;
        repeat (2) @(posedge ck);
        @(negedge ck);
        check_out("reset_release", 9'h000, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].req, vecs[i].divs, vecs[i].note, vecs[i].tone, vecs[i].ms);
            check_out($sformatf("vec%0d", i), vecs[i].exp_wave,
                      vecs[i].exp_sqr, vecs[i].exp_act);
        end

        // Pitch DIV=63: phase holds for exactly 64 tone ticks.
        step(1'b1, 8'd63, 1'b1, 1'b0, 1'b0);
        check_out("div63_noteon", 9'h0FF, 1'b1, 1'b1);
        tone_ticks(63);
        check_out("div63_tick63", 9'h0FF, 1'b1, 1'b1);
        tone_ticks(1);
        check_out("div63_tick64", 9'h101, 1'b0, 1'b1);
        tone_ticks(64);
        check_out("div63_tick128", 9'h0FF, 1'b1, 1'b1);

        // Fresh note for the decay run; phase stays high (no tone ticks).
        step(1'b1, 8'd63, 1'b1, 1'b0, 1'b0);
`ifndef MELODY_CHIME_SLOT_EXP_DECAY_EN
        ms_ticks(4);
        check_out("lin_4ms", 9'h0FE, 1'b1, 1'b1);
        ms_ticks(1015);
        check_out("lin_1019ms", 9'h001, 1'b1, 1'b1);
        ms_ticks(1);
        check_out("lin_1020ms", 9'h000, 1'b1, 1'b0);
        ms_ticks(100);
        check_out("lin_sat", 9'h000, 1'b1, 1'b0);
`else
        ms_ticks(4);
        check_out("exp_step1", 9'h0E0, 1'b1, 1'b1); // 224
        ms_ticks(4);
        check_out("exp_step2", 9'h0C4, 1'b1, 1'b1); // 196
        ms_ticks(4);
        check_out("exp_step3", 9'h0AC, 1'b1, 1'b1); // 172
        ms_ticks(200);
        check_out("exp_done", 9'h000, 1'b1, 1'b0);
        ms_ticks(20);
        check_out("exp_sat", 9'h000, 1'b1, 1'b0);
`endif
        // Oscillator keeps running while silent; sample stays 0.
        tone_ticks(64);
        check_out("silent_osc", 9'h000, 1'b0, 1'b0);

        // Async reset mid-note: outputs clear without waiting for a clock.
        step(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
        check_out("pre_reset_note", 9'h0FF, 1'b1, 1'b1);
        #2;
        xar = 1'b0;
        #1;
        check_out("async_reset", 9'h000, 1'b0, 1'b0);
        @(negedge ck);
        xar = 1'b1;
        tone_ticks(3);
        ms_ticks(5);
        check("post_reset_wave", 32'(wave), 32'h0);
        check("post_reset_active", 32'(active), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
